// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-boundary registers: occupancy state
// encoding, per-boundary widths and control-flag bit positions.
package pipe_pkg;

    // Occupancy of a stage: bit 0 = main entry valid, bit 1 = skid entry valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b11
    } pipe_state_e;

    // Per-boundary widths.
    localparam int IFID_DATA_W  = 64;   // PC + instruction
    localparam int IDEX_CTRL_W  = 8;
    localparam int EXMEM_CTRL_W = 8;
    localparam int MEMWB_CTRL_W = 8;

    // Control-flag bit positions. A bubble drives every one of them low,
    // so a squashed slot never writes a register or touches memory.
    localparam int CTRL_REG_WRITE_BIT  = 0;
    localparam int CTRL_MEM_TO_REG_BIT = 1;
    localparam int CTRL_BRANCH_BIT     = 2;
    localparam int CTRL_MEM_READ_BIT   = 3;
    localparam int CTRL_MEM_WRITE_BIT  = 4;
    localparam int CTRL_ALU_SRC_BIT    = 5;
    localparam int CTRL_JUMP_BIT       = 6;
    localparam int CTRL_USE_IMM_BIT    = 7;

    // The NOP control word for the 8-bit boundaries.
    localparam logic [7:0] CTRL_NOP = 8'h00;

endpackage

// File: rtl/pipe_stage_entry.sv
// One storage slot of a pipeline stage: valid bit plus payload and control.
// clear drops the valid bit (payload keeps its value); load captures a beat.
module pipe_stage_entry
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

    // Next-state: clear wins over load.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            ctrl_d  = ctrl_i;
        end
    end

    // Slot register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the payload is reset as well because the stage must present all-zero data after reset, not only a cleared valid bit.
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with a two-entry skid buffer and synchronous
// flush. in_ready depends only on registered state and flush, never on
// out_ready, so backpressure does not form a combinational path upstream.
// Optional statistics counters are built when PIPE_STAGE_STATS_EN is defined;
// otherwise stall_cnt and flush_cnt are tied to zero.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              main_valid, skid_valid;
    logic [DATA_W-1:0] main_data,  skid_data;
    logic [CTRL_W-1:0] main_ctrl,  skid_ctrl;

    logic              main_load, main_clear, main_from_skid;
    logic              skid_load, skid_clear;
    logic              accept, consume;
    pipe_state_e       state;

    assign state     = pipe_state_e'({skid_valid, main_valid});
    assign in_ready  = !skid_valid && !flush;
    assign out_valid = main_valid && !flush;
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    // Occupancy control: decide which slot loads or clears this cycle.
    always_comb begin
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    main_load = accept;
                end
                ST_FULL: begin
                    if (accept && consume) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                    end else if (consume) begin
                        main_clear = 1'b1;
                    end
                end
                ST_SKID: begin
                    if (consume) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    // Skid without main cannot arise; recover to empty.
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    pipe_stage_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (main_load),
        .clear_i (main_clear),
        .data_i  (main_from_skid ? skid_data : in_data),
        .ctrl_i  (main_from_skid ? skid_ctrl : in_ctrl),
        .valid_o (main_valid),
        .data_o  (main_data),
        .ctrl_o  (main_ctrl)
    );

    pipe_stage_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (in_data),
        .ctrl_i  (in_ctrl),
        .valid_o (skid_valid),
        .data_o  (skid_data),
        .ctrl_o  (skid_ctrl)
    );

    assign out_data = main_data;
    // Bubbles carry an all-zero control word so they behave as a NOP.
    assign out_ctrl = out_valid ? main_ctrl : '0;

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters: stalled output cycles and flushes that squashed a beat.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush && (main_valid || skid_valid) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg. The reference model is a two-deep FIFO queue
// with flush, plus running stall/flush counts. A second instance with
// CNT_W=2 exercises counter saturation on the same stimulus.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        out_valid, out_ready;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        flush;
    logic [15:0] stall_cnt, flush_cnt;

    logic        sat_in_ready, sat_out_valid;
    logic [63:0] sat_out_data;
    logic [7:0]  sat_out_ctrl;
    logic [1:0]  sat_stall_cnt, sat_flush_cnt;

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .CNT_W(16)) dut (
        .clk (clk), .rst_n (rst_n),
        .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data), .in_ctrl (in_ctrl),
        .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data), .out_ctrl (out_ctrl),
        .flush (flush), .stall_cnt (stall_cnt), .flush_cnt (flush_cnt)
    );

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .CNT_W(2)) dut_sat (
        .clk (clk), .rst_n (rst_n),
        .in_valid (in_valid), .in_ready (sat_in_ready), .in_data (in_data), .in_ctrl (in_ctrl),
        .out_valid (sat_out_valid), .out_ready (out_ready), .out_data (sat_out_data), .out_ctrl (sat_out_ctrl),
        .flush (flush), .stall_cnt (sat_stall_cnt), .flush_cnt (sat_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
    } beat_t;

    beat_t       mq[$];
    int          m_stall;
    int          m_flush;
    logic        exp_in_ready, exp_out_valid;
    logic [63:0] exp_data;
    logic [7:0]  exp_ctrl;

    int vectors;
    int miscompares;

    function automatic logic [15:0] exp16(input int n);
        if (!STATS) return 16'd0;
        return (n > 65535) ? 16'hFFFF : 16'(n);
    endfunction

    function automatic logic [1:0] exp2(input int n);
        if (!STATS) return 2'd0;
        return (n > 3) ? 2'd3 : 2'(n);
    endfunction

    // Apply inputs just after a rising edge, predict outputs, settle to the falling edge.
    task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] c,
                         input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = r;
        flush     = f;
        exp_in_ready  = (mq.size() < 2) && !f;
        exp_out_valid = (mq.size() > 0) && !f;
        exp_data      = (mq.size() > 0) ? mq[0].d : 64'd0;
        exp_ctrl      = exp_out_valid ? mq[0].c : 8'd0;
        @(negedge clk);
    endtask

    // Advance the model at the rising edge, then step off the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_stall = 0;
            m_flush = 0;
        end else if (flush) begin
            if (mq.size() > 0) m_flush++;
            mq.delete();
        end else begin
            if (exp_out_valid && !out_ready) m_stall++;
            if (exp_out_valid && out_ready) void'(mq.pop_front());
            if (exp_in_ready && in_valid) mq.push_back('{d: in_data, c: in_ctrl});
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 64'hAAAA, 8'hFF, 1'b0, 1'b0);
        tick();
        drive(1'b1, 64'hAAAA, 8'hFF, 1'b0, 1'b0);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_hold_valid: got %b want 0", out_valid); end
        tick();
        rst_n = 1'b1;
        drive(1'b0, 64'h0, 8'h0, 1'b1, 1'b0);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        vectors++; if (out_data !== 64'd0) begin miscompares++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        vectors++; if (out_ctrl !== 8'd0) begin miscompares++; $display("FAIL rst_out_ctrl: got %h want 0", out_ctrl); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        vectors++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin miscompares++; $display("FAIL rst_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
        tick();
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 64'(i), 8'(i * 3), 1'b1, 1'b0);
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
            if (i > 1) begin
                vectors++; if (out_valid !== 1'b1 || out_data !== 64'(i - 1)) begin miscompares++; $display("FAIL stream_out[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, 64'(i - 1)); end
            end
            tick();
        end
        drive(1'b0, 64'h0, 8'h0, 1'b1, 1'b0);
        vectors++; if (out_valid !== 1'b1 || out_data !== 64'd8) begin miscompares++; $display("FAIL stream_last: got v=%b d=%h want v=1 d=8", out_valid, out_data); end
        tick();
    endtask

    task automatic test_backpressure();
        drive(1'b1, 64'h10, 8'h01, 1'b0, 1'b0); tick();
        drive(1'b1, 64'h11, 8'h02, 1'b0, 1'b0); tick();
        drive(1'b1, 64'h12, 8'h03, 1'b0, 1'b0);
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_skid_ready: got %b want 0", in_ready); end
        vectors++; if (out_valid !== 1'b1 || out_data !== 64'h10) begin miscompares++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=10", out_valid, out_data); end
        tick();
        drive(1'b1, 64'h12, 8'h03, 1'b1, 1'b0);
        vectors++; if (out_data !== 64'h10 || in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_out0: got d=%h rdy=%b want d=10 rdy=0", out_data, in_ready); end
        tick();
        drive(1'b1, 64'h12, 8'h03, 1'b1, 1'b0);
        vectors++; if (out_data !== 64'h11 || in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_out1: got d=%h rdy=%b want d=11 rdy=1", out_data, in_ready); end
        tick();
        drive(1'b0, 64'h0, 8'h0, 1'b1, 1'b0);
        vectors++; if (out_valid !== 1'b1 || out_data !== 64'h12) begin miscompares++; $display("FAIL bp_out2: got v=%b d=%h want v=1 d=12", out_valid, out_data); end
        tick();
        drive(1'b0, 64'h0, 8'h0, 1'b1, 1'b0);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drained: got %b want 0", out_valid); end
        tick();
    endtask

    task automatic test_flush_skid();
        drive(1'b1, 64'h20, 8'h5A, 1'b0, 1'b0); tick();
        drive(1'b1, 64'h21, 8'hA5, 1'b0, 1'b0); tick();
        drive(1'b1, 64'h22, 8'h3C, 1'b0, 1'b1);
        vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_ctrl !== 8'h00) begin miscompares++; $display("FAIL flush_same_cycle: got rdy=%b v=%b c=%h want 0 0 00", in_ready, out_valid, out_ctrl); end
        tick();
        drive(1'b0, 64'h0, 8'h0, 1'b1, 1'b0);
        vectors++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin miscompares++; $display("FAIL flush_after: got v=%b c=%h want 0 00", out_valid, out_ctrl); end
        vectors++; if (flush_cnt !== exp16(m_flush)) begin miscompares++; $display("FAIL flush_cnt: got %0d want %0d", flush_cnt, exp16(m_flush)); end
        vectors++; if (sat_flush_cnt !== exp2(m_flush)) begin miscompares++; $display("FAIL flush_cnt_sat: got %0d want %0d", sat_flush_cnt, exp2(m_flush)); end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 64'h0, 8'h0, 1'b1, 1'b0);
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_no_ghost[%0d]: got v=%b d=%h want v=0", i, out_valid, out_data); end
            tick();
        end
    endtask

    task automatic test_bubble();
        drive(1'b1, 64'h40, 8'hFF, 1'b1, 1'b0); tick();
        drive(1'b0, 64'h0, 8'h0, 1'b1, 1'b0);
        vectors++; if (out_valid !== 1'b1 || out_ctrl !== 8'hFF) begin miscompares++; $display("FAIL bubble_beat: got v=%b c=%h want v=1 c=ff", out_valid, out_ctrl); end
        tick();
        drive(1'b0, 64'h0, 8'h0, 1'b1, 1'b0);
        vectors++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin miscompares++; $display("FAIL bubble_ctrl: got v=%b c=%h want v=0 c=00", out_valid, out_ctrl); end
        vectors++; if (out_data !== 64'h40) begin miscompares++; $display("FAIL bubble_data_hold: got %h want 40", out_data); end
        tick();
    endtask

    task automatic test_stats();
        drive(1'b1, 64'h50, 8'h11, 1'b0, 1'b0); tick();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 64'h0, 8'h0, 1'b0, 1'b0); tick();
        end
        drive(1'b0, 64'h0, 8'h0, 1'b1, 1'b0);
        vectors++; if (stall_cnt !== exp16(m_stall)) begin miscompares++; $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, exp16(m_stall)); end
        vectors++; if (sat_stall_cnt !== exp2(m_stall)) begin miscompares++; $display("FAIL stall_cnt_sat: got %0d want %0d", sat_stall_cnt, exp2(m_stall)); end
        tick();
    endtask

    task automatic test_reset_mid_skid();
        drive(1'b1, 64'h60, 8'h21, 1'b0, 1'b0); tick();
        drive(1'b1, 64'h61, 8'h22, 1'b0, 1'b0); tick();
        rst_n = 1'b0;
        drive(1'b1, 64'h62, 8'h23, 1'b1, 1'b0); tick();
        rst_n = 1'b1;
        drive(1'b0, 64'h0, 8'h0, 1'b1, 1'b0);
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_skid: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
        vectors++; if (stall_cnt !== 16'd0) begin miscompares++; $display("FAIL rst_skid_stall: got %0d want 0", stall_cnt); end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, 8'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            vectors++; if (in_ready !== exp_in_ready) begin miscompares++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", n, in_ready, exp_in_ready); end
            vectors++; if (out_valid !== exp_out_valid) begin miscompares++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", n, out_valid, exp_out_valid); end
            vectors++; if (out_ctrl !== exp_ctrl) begin miscompares++; $display("FAIL rnd_out_ctrl[%0d]: got %h want %h", n, out_ctrl, exp_ctrl); end
            if (exp_out_valid) begin
                vectors++; if (out_data !== exp_data) begin miscompares++; $display("FAIL rnd_out_data[%0d]: got %h want %h", n, out_data, exp_data); end
            end
            vectors++; if (stall_cnt !== exp16(m_stall) || flush_cnt !== exp16(m_flush)) begin miscompares++; $display("FAIL rnd_counters[%0d]: got %0d/%0d want %0d/%0d", n, stall_cnt, flush_cnt, exp16(m_stall), exp16(m_flush)); end
            vectors++; if (sat_stall_cnt !== exp2(m_stall) || sat_flush_cnt !== exp2(m_flush)) begin miscompares++; $display("FAIL rnd_sat_counters[%0d]: got %0d/%0d want %0d/%0d", n, sat_stall_cnt, sat_flush_cnt, exp2(m_stall), exp2(m_flush)); end
            tick();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_stall     = 0;
        m_flush     = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_ctrl     = '0;
        out_ready   = 1'b0;
        flush       = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_skid();
        test_bubble();
        test_stats();
        test_reset_mid_skid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
